// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - PC owner, synchronous imem fetch, ID slot and field extraction
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_en_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        id_valid_o,
    output logic [4:0]  funct_o,
    output logic [4:0]  opcode_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        halted_o,
    output logic        misalign_o,
    output logic [31:0] instr_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_id_pc;
    logic        r_id_valid;
    logic        r_misalign;
    logic [31:0] r_count;
    logic        w_run;
    logic        w_fetch_en;
    logic [31:0] w_id_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start_i) w_state_nxt = S_RUN;
            S_RUN:    if (halt_i)  w_state_nxt = S_HALTED;
            default:  w_state_nxt = r_state;
        endcase
    end

    assign w_run      = (r_state == S_RUN);
    assign w_fetch_en = w_run & ~stall_i & ~redirect_i & ~halt_i;

    // Stall holds everything; the memory holds rdata too, so the ID slot stays coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_id_pc    <= RESET_PC;
            r_id_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= 32'd0;
        end else if (w_run) begin
            if (halt_i) begin
                r_id_valid <= 1'b0;
            end else if (redirect_i) begin
                r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
                r_id_valid <= 1'b0;
                if (redirect_pc_i[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end else if (!stall_i) begin
                r_id_pc    <= r_fetch_pc;
                r_id_valid <= 1'b1;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_fetch_en && r_id_valid) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign w_id_instr    = r_id_valid ? imem_rdata_i : NOP_INSTR;

    assign imem_addr_o   = r_fetch_pc;
    assign imem_en_o     = w_fetch_en;
    assign id_instr_o    = w_id_instr;
    assign id_pc_o       = r_id_pc;
    assign id_valid_o    = r_id_valid;
    assign funct_o       = {w_id_instr[30], w_id_instr[25], w_id_instr[14:12]};
    assign opcode_o      = w_id_instr[6:2];
    assign rs1_o         = w_id_instr[19:15];
    assign rs2_o         = w_id_instr[24:20];
    assign rd_o          = w_id_instr[11:7];
    assign halted_o      = (r_state == S_HALTED);
    assign misalign_o    = r_misalign;
    assign instr_count_o = r_count;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb/tb_fetch_decode_stage.sv - directed bench with behavioural fetch model and per-cycle compare
module tb_fetch_decode_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        halt_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic        imem_en_o;
    logic [31:0] imem_rdata_i = 32'd0;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_valid_o;
    logic [4:0]  funct_o;
    logic [4:0]  opcode_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic        halted_o;
    logic        misalign_o;
    logic [31:0] instr_count_o;

    fetch_decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .imem_addr_o   (imem_addr_o),
        .imem_en_o     (imem_en_o),
        .imem_rdata_i  (imem_rdata_i),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_valid_o    (id_valid_o),
        .funct_o       (funct_o),
        .opcode_o      (opcode_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .rd_o          (rd_o),
        .halted_o      (halted_o),
        .misalign_o    (misalign_o),
        .instr_count_o (instr_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h4020_8133;
            default:       return a ^ 32'h5A5A_0C33;
        endcase
    endfunction

    always @(posedge clk) begin
        if (imem_en_o) imem_rdata_i <= mem_word(imem_addr_o);
    end

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Model: mode 0 idle, 1 running, 2 halted. The ID slot carries "the word at m_id_pc".
    int          m_mode  = 0;
    logic [31:0] m_fetch = 32'd0;
    logic [31:0] m_id_pc = 32'd0;
    bit          m_valid = 1'b0;
    bit          m_mis   = 1'b0;
    logic [31:0] m_count = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_fetch = 0; m_id_pc = 0; m_valid = 0; m_mis = 0; m_count = 0;
        end else if (m_mode == 0) begin
            if (start_i) m_mode = 1;
        end else if (m_mode == 1) begin
            if (halt_i) begin
                m_mode = 2; m_valid = 0;
            end else if (redirect_i) begin
                m_fetch = redirect_pc_i & 32'hFFFF_FFFC;
                m_valid = 0;
                if (redirect_pc_i % 4 != 0) m_mis = 1;
            end else if (!stall_i) begin
                if (m_valid) m_count = m_count + 1;
                m_id_pc = m_fetch;
                m_valid = 1;
                m_fetch = m_fetch + 4;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [31:0] ei;
            ei = m_valid ? mem_word(m_id_pc) : NOP;
            check("imem_addr", imem_addr_o, m_fetch);
            check("imem_en", {31'd0, imem_en_o},
                  {31'd0, (m_mode == 1) && !stall_i && !redirect_i && !halt_i});
            check("id_valid", {31'd0, id_valid_o}, {31'd0, m_valid});
            check("id_pc", id_pc_o, m_id_pc);
            check("id_instr", id_instr_o, ei);
            check("funct", {27'd0, funct_o}, {27'd0, ei[30], ei[25], ei[14:12]});
            check("opcode", {27'd0, opcode_o}, {27'd0, ei[6:2]});
            check("regs", {17'd0, rs1_o, rs2_o, rd_o}, {17'd0, ei[19:15], ei[24:20], ei[11:7]});
            check("halted", {31'd0, halted_o}, {31'd0, m_mode == 2});
            check("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
            check("instr_count", instr_count_o, m_count);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        check("lit_reset_en", {31'd0, imem_en_o}, 32'd0);

        start_i = 1'b1; cyc(1); start_i = 1'b0;
        cyc(1); at_neg();
        check("lit_first_pc", id_pc_o, 32'h0);
        check("lit_first_valid", {31'd0, id_valid_o}, 32'd1);
        check("lit_first_opcode", {27'd0, opcode_o}, 32'b00100);
        check("lit_first_funct", {27'd0, funct_o}, 32'b00000);
        cyc(1); at_neg();
        check("lit_second_pc", id_pc_o, 32'h4);
        check("lit_second_funct", {27'd0, funct_o}, 32'b10000);
        check("lit_second_opcode", {27'd0, opcode_o}, 32'b01100);
        check("lit_second_regs", {17'd0, rs1_o, rs2_o, rd_o}, {17'd0, 5'd1, 5'd2, 5'd2});
        cyc(1);

        stall_i = 1'b1; cyc(3); at_neg();
        check("lit_stall_pc", id_pc_o, 32'h8);
        check("lit_stall_addr", imem_addr_o, 32'hC);
        check("lit_stall_en", {31'd0, imem_en_o}, 32'd0);
        check("lit_stall_count", instr_count_o, 32'd2);
        stall_i = 1'b0; cyc(1);
        check("lit_release_pc", id_pc_o, 32'hC);

        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h40; cyc(1);
        stall_i = 1'b0; redirect_i = 1'b0;
        check("lit_redir_valid", {31'd0, id_valid_o}, 32'd0);
        check("lit_redir_opcode", {27'd0, opcode_o}, 32'b00100);
        check("lit_redir_addr", imem_addr_o, 32'h40);
        cyc(1);
        check("lit_redir_pc", id_pc_o, 32'h40);

        redirect_i = 1'b1; redirect_pc_i = 32'h42; cyc(1); redirect_i = 1'b0;
        check("lit_mis_addr", imem_addr_o, 32'h40);
        check("lit_mis_flag", {31'd0, misalign_o}, 32'd1);
        cyc(2);

        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; cyc(1); redirect_i = 1'b0;
        check("lit_top_addr", imem_addr_o, 32'hFFFF_FFFC);
        cyc(1);
        check("lit_wrap_addr", imem_addr_o, 32'h0);
        check("lit_wrap_pc", id_pc_o, 32'hFFFF_FFFC);
        check("lit_mis_sticky", {31'd0, misalign_o}, 32'd1);

        stall_i = 1'b1; cyc(1);
        #2 rst_n = 1'b0;
        #1;
        check("lit_async_valid", {31'd0, id_valid_o}, 32'd0);
        check("lit_async_mis", {31'd0, misalign_o}, 32'd0);
        check("lit_async_addr", imem_addr_o, 32'h0);
        check("lit_async_count", instr_count_o, 32'd0);
        stall_i = 1'b0; cyc(1);
        rst_n = 1'b1;

        start_i = 1'b1; cyc(1); start_i = 1'b0;
        cyc(3);
        halt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h80; cyc(1);
        halt_i = 1'b0; redirect_i = 1'b0;
        check("lit_halt_flag", {31'd0, halted_o}, 32'd1);
        check("lit_halt_en", {31'd0, imem_en_o}, 32'd0);
        check("lit_halt_addr", imem_addr_o, 32'hC);
        start_i = 1'b1; cyc(2); start_i = 1'b0;
        check("lit_halt_start", {31'd0, halted_o}, 32'd1);
        check("lit_halt_addr2", imem_addr_o, 32'hC);
        cyc(2);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
